// File: rtl/zone_pkg.sv
// zone_pkg: shared mode/state encodings and clog2 helper for zone backlight statistics
package zone_pkg;
  localparam logic [1:0] MODE_MAX = 2'd1;
  localparam logic [1:0] MODE_AVG = 2'd2;
  localparam logic [1:0] MODE_MIX = 2'd3;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_WB = 2'd2;
  localparam logic [1:0] S_SWAP = 2'd3;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/zone_bank_ram.sv
// zone_bank_ram: two-bank zone memory, one write port, two registered read ports on the selected bank
module zone_bank_ram #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input logic I_clk,
  input logic I_we,
  input logic I_wsel,
  input logic [AW-1:0] I_waddr,
  input logic [DW-1:0] I_wdata,
  input logic I_rsel,
  input logic [AW-1:0] I_ra_addr,
  input logic [AW-1:0] I_rb_addr,
  output logic [DW-1:0] O_ra_data,
  output logic [DW-1:0] O_rb_data
);
  logic [DW-1:0] mem [2**(AW+1)];
  always_ff @(posedge I_clk) begin
    if (I_we) mem[{I_wsel, I_waddr}] <= I_wdata;
    O_ra_data <= mem[{I_rsel, I_ra_addr}];
    O_rb_data <= mem[{I_rsel, I_rb_addr}];
  end
endmodule

// File: rtl/zone_backlight_stats.sv
// zone_backlight_stats: per-zone max/avg gray statistics with temporal IIR, ping-pong zone banks and scaled readout
module zone_backlight_stats
  import zone_pkg::*;
#(
  parameter int H_ACT = 1280,
  parameter int V_ACT = 800,
  parameter int ZONES_X = 16,
  parameter int ZONES_Y = 10,
  parameter int DW = 8,
  localparam int AW = clog2(ZONES_X * ZONES_Y)
) (
  input logic I_pix_clk,
  input logic I_rst,
  input logic I_vs,
  input logic I_de,
  input logic [DW-1:0] I_gray,
  input logic [1:0] I_gray_mode,
  input logic [1:0] I_filt_shift,
  input logic [7:0] I_bright,
  input logic [AW-1:0] I_rd_addr,
  output logic [DW-1:0] O_rd_data,
  output logic O_frame_done,
  output logic O_err
);
  localparam int ZW = H_ACT / ZONES_X;
  localparam int ZH = V_ACT / ZONES_Y;
  localparam int LG = clog2(ZW * ZH);
  localparam int SW = DW + LG;
  logic [1:0] st, mode, k;
  logic vs_d, de_d, sel, first, wpend;
  logic vs_rise, line_end, pix, band_end;
  int px, zx, ly, by, wi, wband;
  logic [SW-1:0] sum [ZONES_X];
  logic [DW-1:0] mx [ZONES_X];
  logic [SW-1:0] s_sel;
  logic [DW-1:0] m_sel, avg, mix, v, wv, p, rq, f;
  logic [DW:0] msum;
  logic signed [DW:0] d, sh;
  logic [AW-1:0] wa, za;
  logic [DW+8:0] prod;
  assign vs_rise = I_vs && !vs_d;
  assign line_end = de_d && !I_de;
  assign pix = I_de && st == S_ACCUM && zx < ZONES_X && by < ZONES_Y;
  assign band_end = pix && zx == ZONES_X - 1 && px == ZW - 1 && ly == ZH - 1;
  assign za = AW'(wband * ZONES_X + wi);
  always_comb begin
    s_sel = '0;
    m_sel = '0;
    for (int i = 0; i < ZONES_X; i++)
      if (wi == i) begin
        s_sel = sum[i];
        m_sel = mx[i];
      end
    avg = DW'(s_sel >> LG);
    msum = {1'b0, m_sel} + {1'b0, avg};
    mix = DW'(msum >> 1);
    v = mode == MODE_AVG ? avg : mode == MODE_MIX ? mix : m_sel;
    d = $signed({1'b0, wv}) - $signed({1'b0, p});
    sh = d >>> k;
    f = first ? wv : DW'({1'b0, p} + sh);
    prod = (DW+9)'(rq) * (DW+9)'({1'b0, I_bright} + 9'd1);
  end
  always_ff @(posedge I_pix_clk)
    if (I_rst || vs_rise) begin
      px <= 0;
      zx <= 0;
      ly <= 0;
      by <= 0;
    end else if (line_end) begin
      px <= 0;
      zx <= 0;
      if (by < ZONES_Y) begin
        ly <= ly == ZH - 1 ? 0 : ly + 1;
        by <= ly == ZH - 1 ? by + 1 : by;
      end
    end else if (I_de && zx < ZONES_X) begin
      px <= px == ZW - 1 ? 0 : px + 1;
      zx <= px == ZW - 1 ? zx + 1 : zx;
    end
  always_ff @(posedge I_pix_clk)
    for (int i = 0; i < ZONES_X; i++)
      if (I_rst || vs_rise || (st == S_WB && wi == i)) begin
        sum[i] <= '0;
        mx[i] <= '0;
      end else if (pix && zx == i) begin
        sum[i] <= sum[i] + SW'(I_gray);
        mx[i] <= I_gray > mx[i] ? I_gray : mx[i];
      end
  always_ff @(posedge I_pix_clk)
    if (I_rst) begin
      st <= S_IDLE;
      mode <= '0;
      k <= '0;
      vs_d <= 1'b0;
      de_d <= 1'b0;
      sel <= 1'b0;
      first <= 1'b1;
      wpend <= 1'b0;
      wi <= 0;
      wband <= 0;
      O_err <= 1'b0;
      O_frame_done <= 1'b0;
    end else begin
      vs_d <= I_vs;
      de_d <= I_de;
      wpend <= st == S_WB;
      O_frame_done <= st == S_SWAP;
      if (st == S_SWAP) begin
        sel <= !sel;
        first <= 1'b0;
      end
      if ((I_de && st == S_WB) || (vs_rise && (st == S_ACCUM || st == S_WB))) O_err <= 1'b1;
      if (vs_rise) begin
        st <= S_ACCUM;
        mode <= I_gray_mode;
        k <= I_filt_shift;
      end else if (band_end) begin
        st <= S_WB;
        wi <= 0;
        wband <= by;
      end else if (st == S_WB) begin
        wi <= wi + 1;
        if (wi == ZONES_X - 1) st <= wband == ZONES_Y - 1 ? S_SWAP : S_ACCUM;
      end else if (st == S_SWAP) st <= S_IDLE;
    end
  always_ff @(posedge I_pix_clk) begin
    wv <= v;
    wa <= za;
    O_rd_data <= I_rst ? '0 : DW'(prod >> 8);
  end
  zone_bank_ram #(.DW(DW), .AW(AW)) u_ram (
    .I_clk(I_pix_clk),
    .I_we(wpend),
    .I_wsel(!sel),
    .I_waddr(wa),
    .I_wdata(f),
    .I_rsel(sel),
    .I_ra_addr(za),
    .I_rb_addr(I_rd_addr),
    .O_ra_data(p),
    .O_rb_data(rq)
  );
endmodule

// File: tb/tb_zone_backlight_stats.sv
// tb_zone_backlight_stats: scoreboard bench with directed frames on a 32x16 / 4x2-zone geometry
module tb_zone_backlight_stats;
  logic clk = 1'b0, rst = 1'b1, vs = 1'b0, de = 1'b0;
  logic [7:0] gray = '0, bright = 8'd255, rd_data;
  logic [1:0] gmode = '0, ks = '0;
  logic [2:0] rd_addr = '0;
  logic done, err;
  logic rd_v = 1'b0, rv1 = 1'b0, rv2 = 1'b0;
  int n_cmp = 0, n_bad = 0, n_done = 0, blank = 8, cval = 0, pat = 0;
  int exp_q[$], adr_q[$];
  zone_backlight_stats #(.H_ACT(32), .V_ACT(16), .ZONES_X(4), .ZONES_Y(2), .DW(8)) dut (
    .I_pix_clk(clk),
    .I_rst(rst),
    .I_vs(vs),
    .I_de(de),
    .I_gray(gray),
    .I_gray_mode(gmode),
    .I_filt_shift(ks),
    .I_bright(bright),
    .I_rd_addr(rd_addr),
    .O_rd_data(rd_data),
    .O_frame_done(done),
    .O_err(err)
  );
  always #5 clk = !clk;
  task automatic chk(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask
  always @(posedge clk) begin
    rv1 <= rd_v;
    rv2 <= rv1;
  end
  always @(negedge clk) begin
    int e, a;
    if (done) n_done++;
    if (rv2) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rd_unexpected: got %0d, expected no read", rd_data);
      end else begin
        e = exp_q.pop_front();
        a = adr_q.pop_front();
        chk($sformatf("rd[%0d]", a), int'(rd_data), e);
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  function automatic logic [7:0] pv(input int x, input int y);
    return pat == 1 ? ((x == 10 && y == 12) ? 8'd200 : 8'd0) : 8'(cval);
  endfunction
  task automatic frame(input int pt, input int c, input int m, input int kk, input int nl);
    pat = pt;
    cval = c;
    gmode = 2'(m);
    ks = 2'(kk);
    vs = 1'b1;
    tick(2);
    vs = 1'b0;
    tick(4);
    for (int y = 0; y < nl; y++) begin
      for (int x = 0; x < 32; x++) begin
        de = 1'b1;
        gray = pv(x, y);
        tick(1);
      end
      de = 1'b0;
      tick(blank);
    end
    tick(20);
  endtask
  task automatic rd(input int a, input int e);
    rd_addr = 3'(a);
    rd_v = 1'b1;
    exp_q.push_back(e);
    adr_q.push_back(a);
    tick(1);
  endtask
  task automatic rd_end();
    rd_v = 1'b0;
    tick(4);
  endtask
  task automatic rd_all(input int z5, input int other);
    for (int a = 0; a < 8; a++) rd(a, a == 5 ? z5 : other);
    rd_end();
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    tick(3);
    chk("rst_rd_data", int'(rd_data), 0);
    chk("rst_frame_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    rst = 1'b0;
    tick(2);
    frame(0, 100, 2, 0, 16);
    chk("done_f1", n_done, 1);
    rd_all(100, 100);
    frame(0, 100, 2, 0, 16);
    chk("done_f2", n_done, 2);
    chk("err_clean", int'(err), 0);
    rd_all(100, 100);
    frame(1, 0, 1, 0, 16);
    chk("done_f3", n_done, 3);
    rd_all(200, 0);
    rd(4, 0);
    rd(5, 200);
    rd(6, 0);
    rd(5, 200);
    rd(5, 200);
    rd(0, 0);
    rd_end();
    frame(1, 0, 2, 0, 16);
    rd_all(3, 0);
    frame(0, 0, 2, 0, 16);
    rd_all(0, 0);
    frame(0, 128, 2, 2, 16);
    rd_all(32, 32);
    frame(0, 128, 2, 2, 16);
    rd_all(56, 56);
    frame(1, 0, 3, 0, 16);
    rd_all(101, 0);
    frame(0, 200, 0, 0, 16);
    bright = 8'd127;
    rd_all(100, 100);
    chk("done_f9", n_done, 9);
    chk("err_before_abort", int'(err), 0);
    frame(0, 50, 2, 0, 10);
    chk("done_partial", n_done, 9);
    vs = 1'b1;
    tick(2);
    vs = 1'b0;
    tick(20);
    chk("err_abort", int'(err), 1);
    chk("done_abort", n_done, 9);
    rd_all(100, 100);
    rst = 1'b1;
    tick(2);
    chk("rst2_err", int'(err), 0);
    chk("rst2_rd_data", int'(rd_data), 0);
    rst = 1'b0;
    bright = 8'd255;
    tick(2);
    blank = 2;
    frame(0, 80, 2, 0, 16);
    chk("err_short_blank", int'(err), 1);
    chk("done_short_blank", n_done, 10);
    blank = 8;
    frame(0, 80, 2, 0, 16);
    chk("done_after_short", n_done, 11);
    rd_all(80, 80);
    tick(5);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
